// File: rtl/countdown_pkg.sv
// Shared definitions for the countdown timer: FSM state encoding and default widths.
package countdown_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  localparam int CTR_W_DEF      = 16;
  localparam int PRESCALE_W_DEF = 8;

endpackage

// File: rtl/countdown_prescaler.sv
// Prescaler for the countdown timer: emits a one-cycle tick every P+1 enabled cycles.
module countdown_prescaler #(
  parameter int num_prescalebits = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clear_i,
  input  logic                        enable_i,
  input  logic [num_prescalebits-1:0] p_i,
  output logic                        tick_o
);

  localparam logic [num_prescalebits-1:0] PS_ONE = {{(num_prescalebits-1){1'b0}}, 1'b1};

  logic [num_prescalebits-1:0] cnt_q, cnt_d;

  assign tick_o = enable_i && (cnt_q == p_i);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = (cnt_q == p_i) ? '0 : cnt_q + PS_ONE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with one-cycle expiry pulse.
// Define COUNTDOWN_TIMER_AUTORELOAD_EN for periodic auto-reload on expiry.
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int num_ctrbits      = CTR_W_DEF,
  parameter int num_prescalebits = PRESCALE_W_DEF
) (
  input  logic                        in_clk,
  input  logic                        in_rst,
  input  logic                        in_start,
  input  logic                        in_stop,
  input  logic                        in_pause,
  input  logic [num_ctrbits-1:0]      in_reload,
  input  logic [num_prescalebits-1:0] in_prescale,
  output logic [num_ctrbits-1:0]      out_ctr,
  output logic                        out_busy,
  output logic                        out_done
);

  localparam logic [num_ctrbits-1:0] CTR_ONE = {{(num_ctrbits-1){1'b0}}, 1'b1};

  state_e                      state_q, state_d;
  logic [num_ctrbits-1:0]      ctr_q, ctr_d;
  logic [num_ctrbits-1:0]      rld_q, rld_d;
  logic [num_prescalebits-1:0] psc_q, psc_d;
  logic                        done_q, done_d;
  logic                        presc_clr;
  logic                        presc_en;
  logic                        presc_tick;

  // A PAUSE cycle with pause released counts immediately, so each paused cycle costs exactly one.
  assign presc_en = (state_q != ST_IDLE) && !in_stop && !in_pause;

  countdown_prescaler #(
    .num_prescalebits(num_prescalebits)
  ) u_prescaler (
    .clk_i   (in_clk),
    .rst_i   (in_rst),
    .clear_i (presc_clr),
    .enable_i(presc_en),
    .p_i     (psc_q),
    .tick_o  (presc_tick)
  );

  always_comb begin
    state_d   = state_q;
    ctr_d     = ctr_q;
    rld_d     = rld_q;
    psc_d     = psc_q;
    done_d    = 1'b0;
    presc_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_start) begin
          if (in_reload != '0) begin
            rld_d     = in_reload;
            psc_d     = in_prescale;
            ctr_d     = in_reload;
            presc_clr = 1'b1;
            state_d   = ST_RUN;
          end else begin
            ctr_d  = '0;
            done_d = 1'b1;
          end
        end
      end
      ST_RUN, ST_PAUSE: begin
        if (in_stop) begin
          state_d = ST_IDLE;
        end else if (in_pause) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_RUN;
          if (presc_tick) begin
            if (ctr_q > CTR_ONE) begin
              ctr_d = ctr_q - CTR_ONE;
            end else begin
              done_d = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
              ctr_d  = rld_q;
`else
              ctr_d   = '0;
              state_d = ST_IDLE;
`endif
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      rld_q   <= '0;
      psc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      rld_q   <= rld_d;
      psc_q   <= psc_d;
      done_q  <= done_d;
    end
  end

  assign out_ctr  = ctr_q;
  assign out_busy = (state_q != ST_IDLE);
  assign out_done = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed and randomized bench for countdown_timer against an elapsed-cycle arithmetic model.
module tb_countdown_timer;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic        in_start = 1'b0;
  logic        in_stop = 1'b0;
  logic        in_pause = 1'b0;
  logic [15:0] in_reload = '0;
  logic [7:0]  in_prescale = '0;
  logic [15:0] out_ctr;
  logic        out_busy;
  logic        out_done;

  int n_cmp = 0;
  int n_err = 0;

  // Model: run described by latched R, P and the number of counting cycles n since start.
  bit          m_active = 1'b0;
  int unsigned m_R = 0;
  int unsigned m_P = 0;
  int unsigned m_n = 0;
  int unsigned m_ctr = 0;
  bit          m_done = 1'b0;

  countdown_timer dut (
    .in_clk     (in_clk),
    .in_rst     (in_rst),
    .in_start   (in_start),
    .in_stop    (in_stop),
    .in_pause   (in_pause),
    .in_reload  (in_reload),
    .in_prescale(in_prescale),
    .out_ctr    (out_ctr),
    .out_busy   (out_busy),
    .out_done   (out_done)
  );

  always #5 in_clk = ~in_clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_R = 0; m_P = 0; m_n = 0; m_ctr = 0; m_done = 1'b0;
  endtask

  task automatic model_edge();
    m_done = 1'b0;
    if (in_rst) begin
      model_reset();
    end else if (!m_active) begin
      if (in_start) begin
        if (in_reload != 0) begin
          m_active = 1'b1;
          m_R = in_reload; m_P = in_prescale; m_n = 0; m_ctr = m_R;
        end else begin
          m_ctr = 0; m_done = 1'b1;
        end
      end
    end else if (in_stop) begin
      m_active = 1'b0;
    end else if (!in_pause) begin
      m_n++;
      if (m_n == m_R * (m_P + 1)) begin
        m_done = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
        m_n = 0; m_ctr = m_R;
`else
        m_active = 1'b0; m_ctr = 0;
`endif
      end else begin
        m_ctr = m_R - m_n / (m_P + 1);
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".ctr"},  out_ctr,  m_ctr);
    check({tag, ".busy"}, out_busy, m_active);
    check({tag, ".done"}, out_done, m_done);
  endtask

  task automatic step(input string tag);
    @(posedge in_clk);
    model_edge();
    #1;
    check_outputs(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic start_run(input string tag, input int unsigned r, input int unsigned p);
    in_reload = r[15:0]; in_prescale = p[7:0]; in_start = 1'b1;
    step(tag);
    in_start = 1'b0;
  endtask

  initial begin
    // Reset state.
    step("reset");
    step("reset");
    in_rst = 1'b0;
    step("idle");

    // Asynchronous reset mid-count.
    start_run("r100", 100, 3);
    steps("r100", 7);
    @(negedge in_clk);
    #2 in_rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    step("rst_hold");
    in_rst = 1'b0;
    steps("post_rst", 2);

    // R=5, P=0 and R=3, P=2 with inputs changed mid-run.
    start_run("r5p0", 5, 0);
    in_reload = 16'd77; in_prescale = 8'd9;
    steps("r5p0", 7);
    start_run("r3p2", 3, 2);
    steps("r3p2", 11);

    // Pause for three cycles after the first decrement.
    start_run("pause", 4, 0);
    step("pause");
    in_pause = 1'b1;
    steps("pause_hold", 3);
    check("pause_frozen", out_ctr, 3);
    in_pause = 1'b0;
    steps("pause", 6);

    // Stop together with pause; start ignored while busy.
    start_run("stop", 6, 1);
    in_start = 1'b1; in_reload = 16'd2;
    steps("busy_start", 3);
    in_start = 1'b0;
    in_stop = 1'b1; in_pause = 1'b1;
    step("stop");
    in_stop = 1'b0; in_pause = 1'b0;
    steps("stopped", 3);

    // Zero reload, then back-to-back start in the done cycle.
    start_run("r0", 0, 0);
    steps("r0", 2);
    start_run("b2b", 2, 0);
    step("b2b");
    in_start = 1'b1; in_reload = 16'd3; in_prescale = 8'd0;
    step("b2b_done");
    in_start = 1'b0;
    steps("b2b2", 5);

`ifdef COUNTDOWN_TIMER_AUTORELOAD_EN
    start_run("auto", 2, 1);
    steps("auto", 12);
    in_stop = 1'b1;
    step("auto_stop");
    in_stop = 1'b0;
    steps("auto_idle", 6);
`endif

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      in_start    = ($urandom_range(0, 3) == 0);
      in_stop     = ($urandom_range(0, 29) == 0);
      in_pause    = ($urandom_range(0, 5) == 0);
      in_reload   = 16'($urandom_range(0, 12));
      in_prescale = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) in_rst = 1'b1;
      step("rand");
      in_rst = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
